if_id_queue: RTL
================

# if_id_queue

Instruction queue between the fetch stage and the decode stage of the ARM-subset pipeline. It takes the fetch stage's (pc+4, instruction) pair every cycle, buffers up to DEPTH pairs in order, and presents the oldest pair to decode. Decode stalls no longer have to propagate straight back to the PC register. It also discards all wrong-path instructions when a branch is taken.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- WIDTH, 32: width of the pc and instruction fields.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  fetch presents a pair this cycle (fetch not frozen).
- in_pc  input  WIDTH  fetch stage pc output (already pc+4).
- in_instr  input  WIDTH  fetched instruction.
- in_ready  output  1  queue accepts a push this cycle; drives fetch freeze as ~in_ready.
- flush  input  1  branch taken in execute; discard everything.
- out_ready  input  1  decode consumes the head this cycle (low during hazard freeze).
- out_valid  output  1  head entry present.
- out_pc  output  WIDTH  head pc; 0 when empty.
- out_instr  output  WIDTH  head instruction; 0 when empty, so decode sees a NOP encoding.
- count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {pc, instr}.
- State is wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus count.
- Pointers wrap modulo DEPTH with natural overflow.
- in_ready = (count != DEPTH). It is purely a function of state, not of out_ready: there is no push-through when full.
- out_valid = (count != 0).
- out_pc and out_instr are read combinationally from mem[rd_ptr] when out_valid is high, and are 0 otherwise.
- push = in_valid & in_ready & ~flush. A push writes mem[wr_ptr] and increments wr_ptr.
- pop = out_ready & out_valid & ~flush. A pop increments rd_ptr.
- count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- flush has highest priority. At the next edge: wr_ptr=rd_ptr=0 and count=0. The in_* pair presented in the flush cycle is dropped, because it is wrong-path. Storage contents are don't-care.
- Push when full: impossible, since in_ready=0. in_valid in that cycle is ignored with no state change.
- Pop when empty: ignored, no state change; pointers never underflow.
- Push and pop together at count=DEPTH cannot occur (no push). At count=0 only the push takes effect.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0.
  - out_valid=0, out_pc=0, out_instr=0.
  - in_ready=1.
- Assertion of rst mid-operation clears all pointers and count immediately, without waiting for clk. Buffered entries are lost.

## Timing
- Push-to-output latency is 1 cycle. A pair pushed at edge N appears on out_* after edge N. There is no same-cycle bypass when empty.
- Pop takes effect at the edge: the next entry appears on out_* after the edge where out_ready was sampled high.
- in_ready and out_valid change only after a clk edge or on rst assertion. They are glitch-free functions of count.
- After flush at edge N:
  - out_valid=0 and in_ready=1 from N onward.
  - The first branch-target pair can be pushed in cycle N and appears after edge N+1.
- Sustained throughput is 1 pair/cycle when in_valid and out_ready are both held high.

## Test plan
- Reset: assert rst mid-cycle with count=3 → count=0, out_valid=0, out_instr=0, in_ready=1 immediately, before any clk edge.
- Fill: push pc=4,8,12,16 with out_ready=0 → count=4 and in_ready=0 after the 4th edge. A 5th push of pc=20 is ignored. Draining yields out_pc 4,8,12,16 in order, then out_valid=0.
- Streaming/wrap: out_ready=1, push pc=4..40 (10 pairs) continuously → count holds at 1 after the first edge. out_pc lags in_pc by one cycle and has no gaps across pointer wrap.
- Simultaneous push+pop at count=2 → count stays 2, with head advancing to the next-oldest entry.
- Flush: count=3, assert flush together with in_valid=1 (pc=0x100) and out_ready=1 → after the edge count=0, out_valid=0, and pc=0x100 is not stored. The next push (pc=0x200) appears alone on out_* one edge later.
- Empty pop: count=0, out_ready=1 for 3 cycles with in_valid=0 → count stays 0, out_pc=0, and the pointers are unchanged. The next push is delivered correctly.

Source files
------------

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface if_id_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
);
   logic                     in_valid;
   logic [WIDTH-1:0]         in_pc;
   logic [WIDTH-1:0]         in_instr;
   logic                     in_ready;
   logic                     flush;
   logic                     out_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_pc;
   logic [WIDTH-1:0]         out_instr;
   logic [$clog2(DEPTH):0]   count;

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, count
   );

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, count
   );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - in-order (pc+4, instr) queue between fetch and decode with branch flush
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   if_id_queue_if.slave  q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;

   // Handshake flags depend only on registered count, never on out_ready.
   assign q.in_ready  = (count_q != FULL);
   assign q.out_valid = (count_q != '0);
   assign q.count     = count_q;
   assign q.out_pc    = q.out_valid ? mem_q[rd_ptr_q].pc    : '0;
   assign q.out_instr = q.out_valid ? mem_q[rd_ptr_q].instr : '0;

   assign push = q.in_valid  & q.in_ready  & ~q.flush;
   assign pop  = q.out_ready & q.out_valid & ~q.flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{pc: q.in_pc, instr: q.in_instr};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: reads are masked by out_valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule
